// File: rtl/ad99xx_pkg.sv
// -----------------------------------------------------------------------------
// ad99xx_pkg
// Shared definitions for the AD9911/AD991x SPI register-access engine:
//   - register address constants of the DDS register map
//   - reg_width(): serial data length of a register, 0 when unmapped
//   - state_e: transaction FSM states
// -----------------------------------------------------------------------------
package ad99xx_pkg;

    localparam logic [4:0] CSR   = 5'h00;
    localparam logic [4:0] FR1   = 5'h01;
    localparam logic [4:0] FR2   = 5'h02;
    localparam logic [4:0] CFR   = 5'h03;
    localparam logic [4:0] CTW0  = 5'h04;
    localparam logic [4:0] CPOW0 = 5'h05;
    localparam logic [4:0] ACR   = 5'h06;
    localparam logic [4:0] LSR   = 5'h07;
    localparam logic [4:0] RDW   = 5'h08;
    localparam logic [4:0] FDW   = 5'h09;
    localparam logic [4:0] CW1   = 5'h0A;
    localparam logic [4:0] CW2   = 5'h0B;
    localparam logic [4:0] CW3   = 5'h0C;
    localparam logic [4:0] CW4   = 5'h0D;
    localparam logic [4:0] CW5   = 5'h0E;
    localparam logic [4:0] CW6   = 5'h0F;
    localparam logic [4:0] CW7   = 5'h10;
    localparam logic [4:0] CW8   = 5'h11;
    localparam logic [4:0] CW9   = 5'h12;
    localparam logic [4:0] CW10  = 5'h13;
    localparam logic [4:0] CW11  = 5'h14;
    localparam logic [4:0] CW12  = 5'h15;
    localparam logic [4:0] CW13  = 5'h16;
    localparam logic [4:0] CW14  = 5'h17;
    localparam logic [4:0] CW15  = 5'h18;

    // Instruction byte plus the widest data word.
    localparam int FRAME_W = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_HOLD,
        ST_UPDATE,
        ST_RESP
    } state_e;

    // Data length in bits for a register address; 0 marks an unmapped address.
    function automatic logic [5:0] reg_width(input logic [4:0] addr);
        case (addr)
            CSR:     return 6'd8;
            FR1:     return 6'd24;
            FR2:     return 6'd16;
            CFR:     return 6'd24;
            CTW0:    return 6'd32;
            CPOW0:   return 6'd16;
            ACR:     return 6'd24;
            LSR:     return 6'd16;
            default: return (addr <= CW15) ? 6'd32 : 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/ad99xx_sclk_gen.sv
// -----------------------------------------------------------------------------
// ad99xx_sclk_gen
// SCLK phase generator. Each SCLK period is CLK_DIV cycles low followed by
// CLK_DIV cycles high. The phase ticks flag the last CLK cycle of a phase so
// the FSM can register the change on the same edge as SCLK itself.
//   CLK, RESET_N : clock, synchronous active-low reset
//   en_i         : advance the divider (FSM is shifting bits)
//   clr_i        : restart at the beginning of a low phase
//   sclk_o       : serial clock level
//   rise_o       : SCLK goes high on the next edge
//   fall_o       : SCLK goes low (next bit starts) on the next edge
// -----------------------------------------------------------------------------
module ad99xx_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          last;

    assign last = (cnt_q == LAST);

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (last) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // sees the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign sclk_o = phase_q;
    assign rise_o = en_i & ~phase_q & last;
    assign fall_o = en_i & phase_q & last;

endmodule

// File: rtl/ad99xx_spi_master.sv
// -----------------------------------------------------------------------------
// ad99xx_spi_master
// SPI register-access engine for the AD9911/AD991x DDS (2-wire, MSB-first).
// One transaction per REQ_VALID&REQ_READY: instruction {rw,2'b00,addr} then
// reg_width(addr) data bits. Reads release SDIO for the data bits and shift
// AD_SDIO_I in on each SCLK rise. Writes may be followed by an IO_UPDATE pulse.
// Every transaction ends with a one-cycle RSP_VALID.
//   CLK, RESET_N                     : clock, synchronous active-low reset
//   REQ_VALID/READY/RW/ADDR/DATA/UPDATE : request handshake and fields
//   RSP_VALID/DATA/ERR               : completion strobe, read data, unmapped flag
//   AD_CS, AD_SCLK                   : chip select (active low), serial clock
//   AD_SDIO_O/OE/I                   : SDIO0 tri-state split (pad at top level)
//   AD_UPDATE                        : IO_UPDATE pulse
// -----------------------------------------------------------------------------
module ad99xx_spi_master #(
    parameter int CLK_DIV      = 2,
    parameter int UPDATE_PULSE = 4,
    parameter int CS_HOLD      = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_RW,
    input  logic [4:0]  REQ_ADDR,
    input  logic [31:0] REQ_DATA,
    input  logic        REQ_UPDATE,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        AD_CS,
    output logic        AD_SCLK,
    output logic        AD_SDIO_O,
    output logic        AD_SDIO_OE,
    input  logic        AD_SDIO_I,
    output logic        AD_UPDATE
);

    import ad99xx_pkg::*;

    localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);
    localparam logic [15:0] UPD_LAST  = 16'(UPDATE_PULSE - 1);

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 cs_q, cs_d;
    logic                 sdio_o_q, sdio_o_d;
    logic                 oe_q, oe_d;
    logic                 update_q, update_d;
    logic                 rw_q, rw_d;
    logic                 upd_q, upd_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [31:0]          rx_q, rx_d;
    logic [5:0]           bit_idx_q, bit_idx_d;
    logic [5:0]           last_idx_q, last_idx_d;
    logic [15:0]          tmr_q, tmr_d;

    logic                 sclk_rise, sclk_fall;
    logic [5:0]           width;
    logic [FRAME_W-1:0]   frame;

    // The divider only runs while shifting; outside XFER it is parked at the
    // start of a low phase so the first bit gets a full low phase.
    ad99xx_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .en_i    (state_q == ST_XFER),
        .clr_i   (state_q != ST_XFER),
        .sclk_o  (AD_SCLK),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cs_d        = cs_q;
        sdio_o_d    = sdio_o_q;
        oe_d        = oe_q;
        update_d    = update_q;
        rw_d        = rw_q;
        upd_d       = upd_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_idx_d   = bit_idx_q;
        last_idx_d  = last_idx_q;
        tmr_d       = tmr_q;
        width       = reg_width(REQ_ADDR);
        // Data is left-aligned behind the instruction; reads shift zeros.
        frame       = {REQ_RW, 2'b00, REQ_ADDR,
                       REQ_RW ? 32'h0 : (REQ_DATA << (6'd32 - width))};

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    rw_d  = REQ_RW;
                    upd_d = REQ_UPDATE & ~REQ_RW;
                    if (width == 6'd0) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'h0;
                    end else begin
                        state_d    = ST_XFER;
                        cs_d       = 1'b0;
                        sdio_o_d   = frame[FRAME_W-1];
                        tx_d       = {frame[FRAME_W-2:0], 1'b0};
                        bit_idx_d  = 6'd0;
                        last_idx_d = width + 6'd7;
                        rx_d       = 32'h0;
                    end
                end
            end

            ST_XFER: begin
                if (sclk_rise && rw_q && (bit_idx_q >= 6'd8)) begin
                    rx_d = {rx_q[30:0], AD_SDIO_I};
                end
                if (sclk_fall) begin
                    if (bit_idx_q == last_idx_q) begin
                        state_d  = ST_HOLD;
                        sdio_o_d = 1'b0;
                        oe_d     = 1'b1;
                        tmr_d    = 16'h0;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        sdio_o_d  = tx_q[FRAME_W-1];
                        tx_d      = {tx_q[FRAME_W-2:0], 1'b0};
                        // Hand SDIO to the DDS from the first data bit of a read.
                        if (rw_q && (bit_idx_q >= 6'd7)) begin
                            oe_d = 1'b0;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    cs_d  = 1'b1;
                    tmr_d = 16'h0;
                    if (upd_q) begin
                        state_d  = ST_UPDATE;
                        update_d = 1'b1;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = rw_q ? rx_q : 32'h0;
                    end
                end else begin
                    tmr_d = tmr_q + 16'h1;
                end
            end

            ST_UPDATE: begin
                if (tmr_q == UPD_LAST) begin
                    update_d   = 1'b0;
                    state_d    = ST_RESP;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = 32'h0;
                end else begin
                    tmr_d = tmr_q + 16'h1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and ready are registered decodes of the next state.
        rsp_valid_d = (state_d == ST_RESP);
        ready_d     = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            cs_q        <= 1'b1;
            sdio_o_q    <= 1'b0;
            oe_q        <= 1'b1;
            update_q    <= 1'b0;
            rw_q        <= 1'b0;
            upd_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= 32'h0;
            bit_idx_q   <= 6'd0;
            last_idx_q  <= 6'd0;
            tmr_q       <= 16'h0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cs_q        <= cs_d;
            sdio_o_q    <= sdio_o_d;
            oe_q        <= oe_d;
            update_q    <= update_d;
            rw_q        <= rw_d;
            upd_q       <= upd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_idx_q   <= bit_idx_d;
            last_idx_q  <= last_idx_d;
            tmr_q       <= tmr_d;
        end
    end

    assign REQ_READY  = ready_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ERR    = rsp_err_q;
    assign AD_CS      = cs_q;
    assign AD_SDIO_O  = sdio_o_q;
    assign AD_SDIO_OE = oe_q;
    assign AD_UPDATE  = update_q;

endmodule

// File: tb/tb_ad99xx_spi_master.sv
// -----------------------------------------------------------------------------
// tb_ad99xx_spi_master
// Directed bench for ad99xx_spi_master. Two instances share the request bus:
// u_dut0 with the default parameters (CLK_DIV=2) and u_dut1 with CLK_DIV=1;
// sel chooses which one receives REQ_VALID and which outputs are observed.
// Outputs are sampled on the falling CLK edge. Cycle 1 is the first cycle
// after the accepting rising edge.
// -----------------------------------------------------------------------------
module tb_ad99xx_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, sel;
    logic        req_rw, req_update, sdio_i;
    logic [4:0]  req_addr;
    logic [31:0] req_data;

    logic        ready0, rsp_valid0, rsp_err0, cs0, sclk0, sdio_o0, oe0, update0;
    logic        ready1, rsp_valid1, rsp_err1, cs1, sclk1, sdio_o1, oe1, update1;
    logic [31:0] rsp_data0, rsp_data1;
    logic        valid0, valid1;

    logic        mx_ready, mx_rsp_valid, mx_rsp_err, mx_cs, mx_sclk, mx_sdio_o, mx_oe, mx_update;
    logic [31:0] mx_rsp_data;

    int vectors     = 0;
    int miscompares = 0;

    // Results of the most recent monitored frame.
    int          m_rises, m_cs_cnt, m_cs_first, m_cs_last, m_upd_cnt, m_upd_first;
    int          m_rsp_cyc, m_ready_early, m_oe_instr, m_oe_data, m_sclk_cs_hi;
    logic [63:0] m_bits;
    logic [31:0] m_rsp_data;
    logic        m_rsp_err;

    always #5 clk = ~clk;

    assign valid0 = req_valid & ~sel;
    assign valid1 = req_valid & sel;

    assign mx_ready     = sel ? ready1     : ready0;
    assign mx_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    assign mx_rsp_data  = sel ? rsp_data1  : rsp_data0;
    assign mx_rsp_err   = sel ? rsp_err1   : rsp_err0;
    assign mx_cs        = sel ? cs1        : cs0;
    assign mx_sclk      = sel ? sclk1      : sclk0;
    assign mx_sdio_o    = sel ? sdio_o1    : sdio_o0;
    assign mx_oe        = sel ? oe1        : oe0;
    assign mx_update    = sel ? update1    : update0;

    ad99xx_spi_master u_dut0 (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .REQ_VALID  (valid0),
        .REQ_READY  (ready0),
        .REQ_RW     (req_rw),
        .REQ_ADDR   (req_addr),
        .REQ_DATA   (req_data),
        .REQ_UPDATE (req_update),
        .RSP_VALID  (rsp_valid0),
        .RSP_DATA   (rsp_data0),
        .RSP_ERR    (rsp_err0),
        .AD_CS      (cs0),
        .AD_SCLK    (sclk0),
        .AD_SDIO_O  (sdio_o0),
        .AD_SDIO_OE (oe0),
        .AD_SDIO_I  (sdio_i),
        .AD_UPDATE  (update0)
    );

    ad99xx_spi_master #(
        .CLK_DIV (1)
    ) u_dut1 (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .REQ_VALID  (valid1),
        .REQ_READY  (ready1),
        .REQ_RW     (req_rw),
        .REQ_ADDR   (req_addr),
        .REQ_DATA   (req_data),
        .REQ_UPDATE (req_update),
        .RSP_VALID  (rsp_valid1),
        .RSP_DATA   (rsp_data1),
        .RSP_ERR    (rsp_err1),
        .AD_CS      (cs1),
        .AD_SCLK    (sclk1),
        .AD_SDIO_O  (sdio_o1),
        .AD_SDIO_OE (oe1),
        .AD_SDIO_I  (sdio_i),
        .AD_UPDATE  (update1)
    );

    // Present a request and return right after the rising edge that accepts it.
    task automatic issue(input logic s, input logic rw, input logic [4:0] addr,
                         input logic [31:0] data, input logic upd);
        @(negedge clk);
        sel = s; req_rw = rw; req_addr = addr; req_data = data; req_update = upd;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !mx_ready; i++) @(negedge clk);
        vectors++;
        if (mx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept: REQ_READY=%b required 1", mx_ready);
        end
        @(posedge clk);
    endtask

    // Watch one frame from cycle 1 until RSP_VALID (bounded). At cycle 1 the
    // request inputs are overwritten to prove they were captured. For reads the
    // DDS model presents rd_val MSB-first after each SCLK fall in the data phase.
    task automatic monitor(input logic keep_valid, input logic [4:0] nxt_addr,
                           input logic [31:0] nxt_data, input logic [31:0] rd_val,
                           input int rd_n);
        int   cyc;
        logic prev;
        m_rises = 0; m_cs_cnt = 0; m_cs_first = 0; m_cs_last = 0; m_upd_cnt = 0;
        m_upd_first = 0; m_rsp_cyc = -1; m_ready_early = 0; m_oe_instr = 0;
        m_oe_data = 0; m_sclk_cs_hi = 0; m_bits = '0; m_rsp_data = 'x; m_rsp_err = 1'bx;
        cyc = 0; prev = 1'b0; sdio_i = 1'b0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = keep_valid; req_addr = nxt_addr; req_data = nxt_data;
            end
            if (mx_sclk && !prev) begin
                if (!mx_oe) begin
                    if (m_rises < 8) m_oe_instr++;
                    else             m_oe_data++;
                end
                m_bits = {m_bits[62:0], mx_sdio_o};
                m_rises++;
            end
            if (!mx_sclk && prev && m_rises >= 8 && (m_rises - 8) < rd_n)
                sdio_i = rd_val[rd_n - 1 - (m_rises - 8)];
            prev = mx_sclk;
            if (!mx_cs) begin
                m_cs_cnt++;
                if (m_cs_first == 0) m_cs_first = cyc;
                m_cs_last = cyc;
            end
            if (mx_sclk && mx_cs) m_sclk_cs_hi++;
            if (mx_update) begin
                m_upd_cnt++;
                if (m_upd_first == 0) m_upd_first = cyc;
            end
            if (mx_ready) m_ready_early++;
            if (mx_rsp_valid) begin
                m_rsp_cyc = cyc; m_rsp_data = mx_rsp_data; m_rsp_err = mx_rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; sel = 1'b0; req_rw = 1'b0; req_addr = 5'h0;
        req_data = 32'h0; req_update = 1'b0; sdio_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (mx_cs !== 1'b1)        begin miscompares++; $display("FAIL rst_cs: got %b want 1", mx_cs); end
        vectors++; if (mx_sclk !== 1'b0)      begin miscompares++; $display("FAIL rst_sclk: got %b want 0", mx_sclk); end
        vectors++; if (mx_sdio_o !== 1'b0)    begin miscompares++; $display("FAIL rst_sdio: got %b want 0", mx_sdio_o); end
        vectors++; if (mx_oe !== 1'b1)        begin miscompares++; $display("FAIL rst_oe: got %b want 1", mx_oe); end
        vectors++; if (mx_update !== 1'b0)    begin miscompares++; $display("FAIL rst_update: got %b want 0", mx_update); end
        vectors++; if (mx_ready !== 1'b0)     begin miscompares++; $display("FAIL rst_ready: got %b want 0", mx_ready); end
        vectors++; if (mx_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", mx_rsp_valid); end
        vectors++; if (mx_rsp_data !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_data: got %h want 0", mx_rsp_data); end
        vectors++; if (mx_rsp_err !== 1'b0)   begin miscompares++; $display("FAIL rst_rsp_err: got %b want 0", mx_rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (mx_ready !== 1'b1)     begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", mx_ready); end
    endtask

    task automatic test_write_byte;
        issue(1'b0, 1'b0, 5'h00, 32'h000000F0, 1'b0);
        monitor(1'b0, 5'h1A, 32'hDEADBEEF, 32'h0, 0);
        vectors++; if (m_rises !== 16)            begin miscompares++; $display("FAIL wr8_rises: got %0d want 16", m_rises); end
        vectors++; if (m_bits[15:0] !== 16'h00F0) begin miscompares++; $display("FAIL wr8_bits: got %h want 00f0", m_bits[15:0]); end
        vectors++; if (m_cs_first !== 1 || m_cs_last !== 66 || m_cs_cnt !== 66)
            begin miscompares++; $display("FAIL wr8_cs: got %0d..%0d (%0d) want 1..66 (66)", m_cs_first, m_cs_last, m_cs_cnt); end
        vectors++; if (m_rsp_cyc !== 67)          begin miscompares++; $display("FAIL wr8_rsp_cyc: got %0d want 67", m_rsp_cyc); end
        vectors++; if (m_rsp_err !== 1'b0)        begin miscompares++; $display("FAIL wr8_rsp_err: got %b want 0", m_rsp_err); end
        vectors++; if (m_oe_instr + m_oe_data !== 0) begin miscompares++; $display("FAIL wr8_oe: got %0d low bits want 0", m_oe_instr + m_oe_data); end
        vectors++; if (m_upd_cnt !== 0 || m_sclk_cs_hi !== 0 || m_ready_early !== 0)
            begin miscompares++; $display("FAIL wr8_misc: upd=%0d sclk_cs_hi=%0d ready=%0d want 0/0/0", m_upd_cnt, m_sclk_cs_hi, m_ready_early); end
    endtask

    task automatic test_read;
        issue(1'b0, 1'b1, 5'h05, 32'hFFFFFFFF, 1'b1);
        monitor(1'b0, 5'h00, 32'h0, 32'h0000A5C3, 16);
        vectors++; if (m_rises !== 24)             begin miscompares++; $display("FAIL rd16_rises: got %0d want 24", m_rises); end
        vectors++; if (m_bits[23:16] !== 8'h85)    begin miscompares++; $display("FAIL rd16_instr: got %h want 85", m_bits[23:16]); end
        vectors++; if (m_oe_instr !== 0 || m_oe_data !== 16)
            begin miscompares++; $display("FAIL rd16_oe: instr_low=%0d data_low=%0d want 0/16", m_oe_instr, m_oe_data); end
        vectors++; if (m_rsp_data !== 32'h0000A5C3) begin miscompares++; $display("FAIL rd16_data: got %h want 0000a5c3", m_rsp_data); end
        vectors++; if (m_rsp_cyc !== 99 || m_upd_cnt !== 0)
            begin miscompares++; $display("FAIL rd16_timing: rsp=%0d upd=%0d want 99/0", m_rsp_cyc, m_upd_cnt); end
        vectors++; if (mx_oe !== 1'b1)             begin miscompares++; $display("FAIL rd16_oe_end: got %b want 1", mx_oe); end

        issue(1'b0, 1'b1, 5'h01, 32'h0, 1'b0);
        monitor(1'b0, 5'h00, 32'h0, 32'h005A0FF1, 24);
        vectors++; if (m_bits[31:24] !== 8'h81)    begin miscompares++; $display("FAIL rd24_instr: got %h want 81", m_bits[31:24]); end
        vectors++; if (m_rsp_data !== 32'h005A0FF1) begin miscompares++; $display("FAIL rd24_data: got %h want 005a0ff1", m_rsp_data); end
        vectors++; if (m_oe_data !== 24 || m_rsp_cyc !== 131)
            begin miscompares++; $display("FAIL rd24_timing: oe_low=%0d rsp=%0d want 24/131", m_oe_data, m_rsp_cyc); end
    endtask

    task automatic test_write_update;
        issue(1'b0, 1'b0, 5'h04, 32'h12345678, 1'b1);
        monitor(1'b0, 5'h00, 32'h0, 32'h0, 0);
        vectors++; if (m_rises !== 40)                   begin miscompares++; $display("FAIL wr32_rises: got %0d want 40", m_rises); end
        vectors++; if (m_bits[39:0] !== 40'h0412345678)  begin miscompares++; $display("FAIL wr32_bits: got %h want 0412345678", m_bits[39:0]); end
        vectors++; if (m_cs_last !== 162)                begin miscompares++; $display("FAIL wr32_cs_last: got %0d want 162", m_cs_last); end
        vectors++; if (m_upd_first !== 163 || m_upd_cnt !== 4)
            begin miscompares++; $display("FAIL wr32_update: first=%0d cnt=%0d want 163/4", m_upd_first, m_upd_cnt); end
        vectors++; if (m_rsp_cyc !== 167)                begin miscompares++; $display("FAIL wr32_rsp_cyc: got %0d want 167", m_rsp_cyc); end
        vectors++; if (m_rsp_data !== 32'h0 || m_rsp_err !== 1'b0)
            begin miscompares++; $display("FAIL wr32_rsp: data=%h err=%b want 0/0", m_rsp_data, m_rsp_err); end
    endtask

    task automatic test_unmapped;
        issue(1'b0, 1'b0, 5'h1F, 32'h1, 1'b1);
        monitor(1'b0, 5'h00, 32'h0, 32'h0, 0);
        vectors++; if (m_rsp_cyc !== 1 || m_rsp_err !== 1'b1)
            begin miscompares++; $display("FAIL unm1f_rsp: cyc=%0d err=%b want 1/1", m_rsp_cyc, m_rsp_err); end
        vectors++; if (m_cs_cnt !== 0 || m_rises !== 0 || m_upd_cnt !== 0 || m_sclk_cs_hi !== 0)
            begin miscompares++; $display("FAIL unm1f_pins: cs=%0d rises=%0d upd=%0d want 0/0/0", m_cs_cnt, m_rises, m_upd_cnt); end
        @(negedge clk);
        vectors++; if (mx_ready !== 1'b1) begin miscompares++; $display("FAIL unm1f_ready_c2: got %b want 1", mx_ready); end

        issue(1'b0, 1'b1, 5'h19, 32'h0, 1'b0);
        monitor(1'b0, 5'h00, 32'h0, 32'h0, 0);
        vectors++; if (m_rsp_cyc !== 1 || m_rsp_err !== 1'b1 || m_rsp_data !== 32'h0)
            begin miscompares++; $display("FAIL unm19_rsp: cyc=%0d err=%b data=%h want 1/1/0", m_rsp_cyc, m_rsp_err, m_rsp_data); end
    endtask

    task automatic test_reset_mid;
        int   rises, seen;
        logic prev;
        issue(1'b0, 1'b0, 5'h04, 32'hCAFEF00D, 1'b1);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 400 && rises < 30; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mx_sclk && !prev) rises++;
            prev = mx_sclk;
        end
        vectors++; if (rises !== 30) begin miscompares++; $display("FAIL rstmid_reach: got %0d rises want 30", rises); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (mx_cs !== 1'b1 || mx_sclk !== 1'b0 || mx_oe !== 1'b1)
            begin miscompares++; $display("FAIL rstmid_pins: cs=%b sclk=%b oe=%b want 1/0/1", mx_cs, mx_sclk, mx_oe); end
        vectors++; if (mx_sdio_o !== 1'b0 || mx_update !== 1'b0 || mx_ready !== 1'b0)
            begin miscompares++; $display("FAIL rstmid_out: sdio=%b upd=%b ready=%b want 0/0/0", mx_sdio_o, mx_update, mx_ready); end
        seen = 0;
        if (mx_rsp_valid) seen++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mx_rsp_valid) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rstmid_no_rsp: got %0d strobes want 0", seen); end

        issue(1'b0, 1'b0, 5'h02, 32'h00008001, 1'b0);
        monitor(1'b0, 5'h04, 32'h0, 32'h0, 0);
        vectors++; if (m_rises !== 24 || m_bits[23:0] !== 24'h028001)
            begin miscompares++; $display("FAIL rstmid_after: rises=%0d bits=%h want 24/028001", m_rises, m_bits[23:0]); end
        vectors++; if (m_rsp_cyc !== 99 || m_rsp_err !== 1'b0)
            begin miscompares++; $display("FAIL rstmid_after_rsp: cyc=%0d err=%b want 99/0", m_rsp_cyc, m_rsp_err); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 1'b0, 5'h00, 32'h000000A5, 1'b0);
        // VALID stays high; the second request's fields replace the first's at cycle 1.
        monitor(1'b1, 5'h02, 32'h0000BEEF, 32'h0, 0);
        vectors++; if (m_rises !== 16 || m_bits[15:0] !== 16'h00A5)
            begin miscompares++; $display("FAIL b2b1_bits: rises=%0d bits=%h want 16/00a5", m_rises, m_bits[15:0]); end
        vectors++; if (m_rsp_cyc !== 35 || m_cs_last !== 34)
            begin miscompares++; $display("FAIL b2b1_timing: rsp=%0d cs_last=%0d want 35/34", m_rsp_cyc, m_cs_last); end
        vectors++; if (m_ready_early !== 0) begin miscompares++; $display("FAIL b2b1_ready: got %0d early cycles want 0", m_ready_early); end
        @(negedge clk);
        vectors++; if (mx_cs !== 1'b1 || mx_ready !== 1'b1)
            begin miscompares++; $display("FAIL b2b_gap: cs=%b ready=%b want 1/1", mx_cs, mx_ready); end
        @(posedge clk);
        monitor(1'b0, 5'h1B, 32'hFFFFFFFF, 32'h0, 0);
        vectors++; if (m_rises !== 24 || m_bits[23:0] !== 24'h02BEEF)
            begin miscompares++; $display("FAIL b2b2_bits: rises=%0d bits=%h want 24/02beef", m_rises, m_bits[23:0]); end
        vectors++; if (m_cs_first !== 1 || m_rsp_cyc !== 51)
            begin miscompares++; $display("FAIL b2b2_timing: cs_first=%0d rsp=%0d want 1/51", m_cs_first, m_rsp_cyc); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_byte();
        test_read();
        test_write_update();
        test_unmapped();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
